fft16_stage1_ctrl: RTL and testbench
====================================

FFT16_STAGE1_CTRL -- requirements
Module: fft16_stage1_ctrl

Interface
REQ-001 SHALL have parameter BF_LAT, default 1: clock cycles from stable butterfly-stage inputs to valid butterfly-stage outputs (legal range 1..7).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have ports in_re / in_im, input, 16 bits each: serial input sample, two's complement.
REQ-005 SHALL have port in_valid, input, 1 bit: input sample present.
REQ-006 SHALL have port in_last, input, 1 bit: marks the final sample of a frame.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-008 SHALL have ports bf_re_in / bf_im_in, output, 256 bits each: packed inputs to the first-stage radix-4 datapath; sample k occupies bits [16k+15:16k].
REQ-009 SHALL have ports bf_re_out / bf_im_out, input, 256 bits each: packed datapath results, same packing.
REQ-010 SHALL have ports out_re / out_im, output, 16 bits each: serial result sample.
REQ-011 SHALL have ports out_valid and out_last, output, 1 bit each: result present; final result of the frame.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port busy, output, 1 bit: high in COMPUTE or UNLOAD.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a malformed frame.

Function
REQ-015 SHALL implement states LOAD, COMPUTE, UNLOAD with a 4-bit sample index idx and a 3-bit wait counter wcnt.
REQ-016 In LOAD: in_ready=1; input handshake is in_valid&in_ready; each handshake writes in_re/in_im to input buffer slot idx and increments idx.
REQ-017 Handshake with idx=15 and in_last=1 SHALL move to COMPUTE, clear idx and wcnt.
REQ-018 Handshake with in_last=1 and idx!=15, or with idx=15 and in_last=0, SHALL pulse frame_err next cycle, clear idx, and remain in LOAD; buffer contents are discarded and no output is produced.
REQ-019 bf_re_in/bf_im_in SHALL continuously reflect the input buffer; the buffer SHALL NOT change outside LOAD handshakes.
REQ-020 COMPUTE SHALL last exactly BF_LAT+1 cycles (wcnt 0..BF_LAT); in the cycle wcnt=BF_LAT, bf_re_out/bf_im_out SHALL be captured into the output buffer, and the state SHALL change to UNLOAD.
REQ-021 In UNLOAD: out_valid=1; out_re/out_im = output buffer slot idx (natural order 0..15); out_last=1 only when idx=15.
REQ-022 Output handshake out_valid&out_ready SHALL increment idx; out_ready low SHALL hold out_re/out_im/out_last stable.
REQ-023 Handshake at idx=15 SHALL return to LOAD with idx=0; in_ready SHALL be 1 in the next cycle.
REQ-024 in_ready SHALL be 0 in COMPUTE and UNLOAD; in_valid is ignored there (no overlap of frames).
REQ-025 Data SHALL pass unmodified (no scaling, no width change); the datapath owns all arithmetic.
REQ-026 Minimum frame period: 16 load + BF_LAT+1 compute + 16 unload cycles = 34 cycles for BF_LAT=1.

Reset
REQ-027 While rst_n=0 at a rising edge: state=LOAD, idx=0, wcnt=0, in_ready=0, out_valid=0, out_last=0, out_re=out_im=0, busy=0, frame_err=0, input and output buffers cleared to 0 (so bf_re_in/bf_im_in=0).
REQ-028 in_ready SHALL rise in the first cycle after rst_n returns high.
REQ-029 Reset asserted in any state mid-frame SHALL abandon the frame with no partial output.

Verification
REQ-030 Impulse: frame re=1 at sample 0, all else 0, in_last on 16th, out_ready=1 -> bf_re_in word0=1, after BF_LAT+1 cycles out_valid, 16 outputs equal captured bf_re_out words 0..15, out_last on 16th only.
REQ-031 Backpressure: out_ready toggled 1,0,0,1 repeating during UNLOAD -> every result delivered exactly once in order, outputs stable while out_ready=0.
REQ-032 Short frame: in_last on 5th sample -> frame_err pulses one cycle, busy stays 0, next full 16-sample frame processes correctly.
REQ-033 Missing last: 16 samples with in_last=0 -> frame_err, no COMPUTE entry.
REQ-034 Reset mid-UNLOAD after 7 outputs -> next cycle out_valid=0, all outputs 0, in_ready=1 one cycle after release.
REQ-035 Back-to-back: two frames with in_valid held high, BF_LAT=3 -> in_ready=0 for exactly 4+16 cycles between frames, both frames correct.

Source files
------------

// File: rtl/fft16_stage1_ctrl.sv
// Load/compute/unload control around a 16-point first-stage radix-4 datapath.
// Collects a serial frame, presents it in parallel, captures results, streams them out.
module fft16_stage1_ctrl #(
    parameter int BF_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  in_re,
    input  logic [15:0]  in_im,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [255:0] bf_re_in,
    output logic [255:0] bf_im_in,
    input  logic [255:0] bf_re_out,
    input  logic [255:0] bf_im_out,
    output logic [15:0]  out_re,
    output logic [15:0]  out_im,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic         frame_err
);

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    localparam logic [2:0] LAT = 3'(BF_LAT);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  idx;
    logic [2:0]  wcnt;
    logic        run;
    logic [15:0] ibuf_re [16];
    logic [15:0] ibuf_im [16];
    logic [15:0] obuf_re [16];
    logic [15:0] obuf_im [16];
    logic        in_hs;
    logic        out_hs;
    logic        idx_end;
    logic        frame_ok;
    logic        frame_bad;
    logic        cap;

    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign idx_end   = (idx == 4'd15);
    assign frame_ok  = in_hs & in_last & idx_end;
    assign frame_bad = in_hs & (in_last ^ idx_end);
    assign cap       = (state == COMPUTE) && (wcnt == LAT);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (frame_ok) state_nx = COMPUTE;
            COMPUTE: if (cap) state_nx = UNLOAD;
            UNLOAD:  if (out_hs && idx_end) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = run && (state == LOAD);
        out_valid = (state == UNLOAD);
        out_last  = out_valid && idx_end;
        busy      = (state != LOAD);
        out_re    = out_valid ? obuf_re[idx] : 16'd0;
        out_im    = out_valid ? obuf_im[idx] : 16'd0;
    end

    // run holds in_ready low for the first cycle after reset release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run       <= 1'b0;
            idx       <= 4'd0;
            wcnt      <= 3'd0;
            frame_err <= 1'b0;
        end else begin
            run       <= 1'b1;
            frame_err <= frame_bad;
            unique case (state)
                LOAD: begin
                    wcnt <= 3'd0;
                    if (in_hs) begin
                        if (in_last || idx_end) idx <= 4'd0;
                        else                    idx <= idx + 4'd1;
                    end
                end
                COMPUTE: begin
                    idx  <= 4'd0;
                    wcnt <= wcnt + 3'd1;
                end
                UNLOAD: begin
                    if (out_hs) idx <= idx + 4'd1;
                end
                default: idx <= 4'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                ibuf_re[k] <= 16'd0;
                ibuf_im[k] <= 16'd0;
                obuf_re[k] <= 16'd0;
                obuf_im[k] <= 16'd0;
            end
        end else begin
            if (in_hs) begin
                ibuf_re[idx] <= in_re;
                ibuf_im[idx] <= in_im;
            end
            if (cap) begin
                for (int k = 0; k < 16; k++) begin
                    obuf_re[k] <= bf_re_out[16*k +: 16];
                    obuf_im[k] <= bf_im_out[16*k +: 16];
                end
            end
        end
    end

    always_comb begin
        bf_re_in = '0;
        bf_im_in = '0;
        for (int k = 0; k < 16; k++) begin
            bf_re_in[16*k +: 16] = ibuf_re[k];
            bf_im_in[16*k +: 16] = ibuf_im[k];
        end
    end

endmodule

// File: tb/tb_fft16_stage1_ctrl.sv
// Bench for fft16_stage1_ctrl: scoreboard of expected results, a delayed
// datapath model, and one task per scenario.
module tb_fft16_stage1_ctrl;

    localparam int LAT = 3;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [15:0]  in_re;
    logic [15:0]  in_im;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [255:0] bf_re_in;
    logic [255:0] bf_im_in;
    logic [255:0] bf_re_out;
    logic [255:0] bf_im_out;
    logic [15:0]  out_re;
    logic [15:0]  out_im;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic         frame_err;

    int   total;
    int   bad;
    exp_t sb[$];
    logic [15:0] fr_re [16];
    logic [15:0] fr_im [16];

    fft16_stage1_ctrl #(.BF_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_re(in_re), .in_im(in_im),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .bf_re_in(bf_re_in), .bf_im_in(bf_im_in),
        .bf_re_out(bf_re_out), .bf_im_out(bf_im_out),
        .out_re(out_re), .out_im(out_im),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // datapath stand-in: word k <- reversed input plus 3k (re), inverted (im)
    logic [255:0] pipe_re [LAT];
    logic [255:0] pipe_im [LAT];
    always @(posedge clk) begin
        for (int k = 0; k < 16; k++) begin
            pipe_re[0][16*k +: 16] <= bf_re_in[16*(15-k) +: 16] + 16'(3*k);
            pipe_im[0][16*k +: 16] <= ~bf_im_in[16*k +: 16];
        end
        for (int i = 1; i < LAT; i++) begin
            pipe_re[i] <= pipe_re[i-1];
            pipe_im[i] <= pipe_im[i-1];
        end
    end
    assign bf_re_out = pipe_re[LAT-1];
    assign bf_im_out = pipe_im[LAT-1];

    exp_t held;
    logic hold_chk;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (hold_chk) begin
                total++;
                if ({out_re, out_im, out_last} !== held) begin
                    bad++;
                    $display("FAIL out_stable got %h want %h",
                             {out_re, out_im, out_last}, held);
                end
            end
            if (out_ready) begin
                hold_chk = 1'b0;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out got re=%h im=%h want none",
                             out_re, out_im);
                end else begin
                    e = sb.pop_front();
                    if ({out_re, out_im, out_last} !== e) begin
                        bad++;
                        $display("FAIL out_data got re=%h im=%h last=%b want re=%h im=%h last=%b",
                                 out_re, out_im, out_last, e.re, e.im, e.last);
                    end
                end
            end else begin
                hold_chk = 1'b1;
                held = {out_re, out_im, out_last};
            end
        end else begin
            hold_chk = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input int last_at,
                              input bit impulse, input bit hold);
        int g;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            fr_re[k] = impulse ? 16'(k == 0) : 16'($urandom_range(0, 65535));
            fr_im[k] = impulse ? 16'd0 : 16'($urandom_range(0, 65535));
            in_re    = fr_re[k];
            in_im    = fr_im[k];
            in_last  = (k == last_at);
            in_valid = 1'b1;
            g = 0;
            while (in_ready !== 1'b1 && g < 200) begin
                step();
                g++;
            end
            if (g >= 200) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout got 0 want 1");
            end
            step();
        end
        if (!hold) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        if (n == 16 && last_at == 15) begin
            for (int k = 0; k < 16; k++) begin
                e.re   = fr_re[15-k] + 16'(3*k);
                e.im   = ~fr_im[k];
                e.last = (k == 15);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain(input bit bp, output int lowcnt);
        int g;
        lowcnt = 0;
        g = 0;
        while (!(in_ready === 1'b1 && sb.size() == 0) && g < 300) begin
            if (in_ready !== 1'b1) lowcnt++;
            out_ready = bp ? (g % 4 == 0 || g % 4 == 3) : 1'b1;
            step();
            g++;
        end
        out_ready = 1'b1;
        if (g >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got left=%0d want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if ({in_ready, out_valid, out_last, busy, frame_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got %b want 00000",
                     {in_ready, out_valid, out_last, busy, frame_err});
        end
        total++;
        if ({bf_re_in, bf_im_in, out_re, out_im} !== '0) begin
            bad++;
            $display("FAIL reset_data got re0=%h out=%h want 0",
                     bf_re_in[15:0], out_re);
        end
        rst_n = 1'b1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL release_early got %b want 0", in_ready);
        end
        step();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_impulse();
        int lc;
        int early;
        out_ready = 1'b1;
        send_frame(16, 15, 1'b1, 1'b0);
        total++;
        if (bf_re_in[15:0] !== 16'd1 || bf_re_in[255:16] !== '0) begin
            bad++;
            $display("FAIL impulse_bfin got w0=%h rest=%0d want 1/0",
                     bf_re_in[15:0], bf_re_in[255:16] != '0);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL impulse_busy got %b want 1", busy);
        end
        early = 0;
        for (int i = 0; i <= LAT; i++) begin
            if (out_valid !== 1'b0) early++;
            step();
        end
        total++;
        if (early != 0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL impulse_latency got early=%0d valid=%b want 0/1",
                     early, out_valid);
        end
        drain(1'b0, lc);
    endtask

    task automatic test_backpressure();
        int lc;
        send_frame(16, 15, 1'b0, 1'b0);
        drain(1'b1, lc);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL bp_left got %0d want 0", sb.size());
        end
    endtask

    task automatic test_short_frame();
        int lc;
        send_frame(5, 4, 1'b0, 1'b0);
        total++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL short_err got err=%b busy=%b want 1/0", frame_err, busy);
        end
        step();
        total++;
        if (frame_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL short_after got err=%b busy=%b rdy=%b want 0/0/1",
                     frame_err, busy, in_ready);
        end
        send_frame(16, 15, 1'b0, 1'b0);
        drain(1'b0, lc);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL short_next got %0d want 0", sb.size());
        end
    endtask

    task automatic test_missing_last();
        int seen;
        send_frame(16, -1, 1'b0, 1'b0);
        total++;
        if (frame_err !== 1'b1) begin
            bad++;
            $display("FAIL nolast_err got %b want 1", frame_err);
        end
        seen = 0;
        repeat (8) begin
            step();
            if (busy !== 1'b0 || out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL nolast_compute got %0d want 0", seen);
        end
    endtask

    task automatic test_reset_mid_unload();
        int g;
        out_ready = 1'b1;
        send_frame(16, 15, 1'b0, 1'b0);
        g = 0;
        while (out_valid !== 1'b1 && g < 50) begin
            step();
            g++;
        end
        total++;
        if (g >= 50) begin
            bad++;
            $display("FAIL rmu_timeout got 0 want 1");
        end
        repeat (7) step();
        total++;
        if (sb.size() != 9) begin
            bad++;
            $display("FAIL rmu_count got %0d want 9", sb.size());
        end
        rst_n = 1'b0;
        out_ready = 1'b0;
        step();
        sb.delete();
        total++;
        if ({out_valid, out_last, out_re, out_im, in_ready, busy} !== '0) begin
            bad++;
            $display("FAIL rmu_outs got v=%b l=%b re=%h im=%h rdy=%b busy=%b want 0",
                     out_valid, out_last, out_re, out_im, in_ready, busy);
        end
        rst_n = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmu_release got rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lc;
        out_ready = 1'b1;
        send_frame(16, 15, 1'b0, 1'b1);
        drain(1'b0, lc);
        total++;
        if (lc != LAT + 1 + 16) begin
            bad++;
            $display("FAIL b2b_gap got %0d want %0d", lc, LAT + 17);
        end
        send_frame(16, 15, 1'b0, 1'b0);
        drain(1'b0, lc);
        total++;
        if (sb.size() != 0 || lc != LAT + 1 + 16) begin
            bad++;
            $display("FAIL b2b_second got left=%0d gap=%0d want 0/%0d",
                     sb.size(), lc, LAT + 17);
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_re     = '0;
        in_im     = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        total     = 0;
        bad       = 0;
        hold_chk  = 1'b0;
        test_reset();
        test_impulse();
        test_backpressure();
        test_short_frame();
        test_missing_last();
        test_reset_mid_unload();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
